pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined CPU; generalises the single-cycle PC register. Holds the fetch address and supports a post-reset boot delay, pipeline stall, branch/jump redirect, exception entry, exception return and halt. Flags misaligned or out-of-range fetch addresses. Sits at the front of the F stage, feeding the instruction memory address and the F/D pipeline register.

---
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit : program-counter unit at the front of the fetch stage.
//
// Holds the fetch address and sequences it through a short post-reset boot
// delay, normal sequential fetch, hazard stalls, branch/jump redirects,
// exception entry/return and halt. Fetch addresses that are misaligned or
// fall outside the instruction-memory window are flagged, but still loaded.
//
// Ports
//   Clk            clock, all state updates on the rising edge
//   Reset          synchronous, active-high; returns to BOOT at RESET_ADDR
//   Stall          hold Pc for this edge
//   RedirectValid  load RedirectPC (branch/jump taken)
//   RedirectPC     redirect target
//   ExcReq         load EXC_VECTOR
//   EretReq        load Epc
//   Epc            exception return address from CP0
//   Halt           stop fetching until Reset
//   Pc             registered fetch address
//   PcValid        Pc is a live fetch (RUN only)
//   FetchExc       Pc misaligned or outside the fetch window (combinational)
//   State          FSM state: 0 BOOT, 1 RUN, 2 HALT
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [31:0] RESET_ADDR  = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter logic [31:0] IM_BASE     = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES    = 32'h0000_4000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             RedirectValid,
    input  logic [WIDTH-1:0] RedirectPC,
    input  logic             ExcReq,
    input  logic             EretReq,
    input  logic [WIDTH-1:0] Epc,
    input  logic             Halt,
    output logic [WIDTH-1:0] Pc,
    output logic             PcValid,
    output logic             FetchExc,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int unsigned      CNT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_ADDR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);
    // Window bounds carry one extra bit so IM_BASE + IM_BYTES cannot wrap.
    localparam logic [WIDTH:0]   WIN_LO   = (WIDTH + 1)'(IM_BASE);
    localparam logic [WIDTH:0]   WIN_HI   = WIN_LO + (WIDTH + 1)'(IM_BYTES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= BOOT;
            pc_q    <= RST_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: begin
                // Pc stays at RESET_ADDR, so the first RUN cycle fetches it.
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (ExcReq) begin
                    pc_d = EXC_PC;
                end else if (EretReq) begin
                    pc_d = Epc;
                end else if (Stall) begin
                    // A redirect arriving during a stall is dropped; the
                    // issuing stage re-asserts it once the stall clears.
                    pc_d = pc_q;
                end else if (RedirectValid) begin
                    pc_d = RedirectPC;
                end else begin
                    pc_d = pc_q + WIDTH'(4);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
                pc_d    = RST_PC;
                cnt_d   = '0;
            end
        endcase
    end

    assign Pc       = pc_q;
    assign State    = state_q;
    assign PcValid  = (state_q == RUN);
    assign FetchExc = PcValid & ((pc_q[1:0] != 2'b00)
                               | ({1'b0, pc_q} < WIN_LO)
                               | ({1'b0, pc_q} >= WIN_HI));

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit : directed testbench for pc_unit.
// Main instance uses default parameters; a second 8-bit instance with a
// full 256-byte window covers the silent Pc wrap.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    // default-parameter instance
    logic        Reset, Stall, RedirectValid, ExcReq, EretReq, Halt;
    logic [31:0] RedirectPC, Epc, Pc;
    logic        PcValid, FetchExc;
    logic [1:0]  State;

    pc_unit dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Stall         (Stall),
        .RedirectValid (RedirectValid),
        .RedirectPC    (RedirectPC),
        .ExcReq        (ExcReq),
        .EretReq       (EretReq),
        .Epc           (Epc),
        .Halt          (Halt),
        .Pc            (Pc),
        .PcValid       (PcValid),
        .FetchExc      (FetchExc),
        .State         (State)
    );

    // 8-bit instance
    logic       s_reset, s_redir_valid;
    logic [7:0] s_redir_pc, s_pc;
    logic       s_pc_valid, s_fetch_exc;
    logic [1:0] s_state;

    pc_unit #(
        .WIDTH       (8),
        .RESET_ADDR  (32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080),
        .IM_BASE     (32'h0000_0000),
        .IM_BYTES    (32'h0000_0100),
        .BOOT_CYCLES (2)
    ) dut8 (
        .Clk           (Clk),
        .Reset         (s_reset),
        .Stall         (1'b0),
        .RedirectValid (s_redir_valid),
        .RedirectPC    (s_redir_pc),
        .ExcReq        (1'b0),
        .EretReq       (1'b0),
        .Epc           (8'h00),
        .Halt          (1'b0),
        .Pc            (s_pc),
        .PcValid       (s_pc_valid),
        .FetchExc      (s_fetch_exc),
        .State         (s_state)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // advance one rising edge, then settle before sampling
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Stall = 1'b0; RedirectValid = 1'b0; ExcReq = 1'b0;
        EretReq = 1'b0; Halt = 1'b0;
    endtask

    task automatic chk_run(input string tag, input logic [31:0] exp_pc, input logic exp_fexc);
        check({tag, ".pc"},    Pc,       exp_pc);
        check({tag, ".state"}, 32'(State), 32'd1);
        check({tag, ".vld"},   32'(PcValid), 32'd1);
        check({tag, ".fexc"},  32'(FetchExc), 32'(exp_fexc));
    endtask

    task automatic chk_boot(input string tag);
        check({tag, ".pc"},    Pc,         32'h3000);
        check({tag, ".state"}, 32'(State), 32'd0);
        check({tag, ".vld"},   32'(PcValid), 32'd0);
        check({tag, ".fexc"},  32'(FetchExc), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; idle_inputs();
        RedirectPC = 32'h0; Epc = 32'h0;
        s_reset = 1'b1; s_redir_valid = 1'b0; s_redir_pc = 8'h00;

        // reset state and boot
        step();
        chk_boot("rst");
        Reset = 1'b0;
        step();
        chk_boot("boot1");
        step();
        chk_run("boot_run0", 32'h3000, 1'b0);
        step();
        chk_run("boot_run1", 32'h3004, 1'b0);
        step();
        chk_run("boot_run2", 32'h3008, 1'b0);

        // exception priority over eret and stall
        ExcReq = 1'b1; EretReq = 1'b1; Stall = 1'b1; Epc = 32'h3020;
        step();
        chk_run("exc", 32'h4180, 1'b0);
        idle_inputs(); EretReq = 1'b1;
        step();
        chk_run("eret", 32'h3020, 1'b0);

        // stall masks redirect
        idle_inputs(); RedirectValid = 1'b1; RedirectPC = 32'h3010;
        step();
        chk_run("redir", 32'h3010, 1'b0);
        Stall = 1'b1; RedirectPC = 32'h3100;
        step();
        chk_run("stall0", 32'h3010, 1'b0);
        step();
        chk_run("stall1", 32'h3010, 1'b0);
        Stall = 1'b0;
        step();
        chk_run("redir_after", 32'h3100, 1'b0);
        idle_inputs();
        step();
        chk_run("seq", 32'h3104, 1'b0);

        // fault flags
        RedirectValid = 1'b1; RedirectPC = 32'h3002;
        step();
        chk_run("misalign", 32'h3002, 1'b1);
        RedirectPC = 32'h7000;
        step();
        chk_run("upper", 32'h7000, 1'b1);
        RedirectPC = 32'h6FFC;
        step();
        chk_run("last_ok", 32'h6FFC, 1'b0);
        RedirectPC = 32'h2FFC;
        step();
        chk_run("lower", 32'h2FFC, 1'b1);
        RedirectPC = 32'h3040;
        step();
        chk_run("to_halt", 32'h3040, 1'b0);

        // halt ignores everything but reset
        idle_inputs(); Halt = 1'b1;
        step();
        check("halt.state", 32'(State), 32'd2);
        check("halt.pc",    Pc, 32'h3040);
        check("halt.vld",   32'(PcValid), 32'd0);
        check("halt.fexc",  32'(FetchExc), 32'd0);
        Halt = 1'b0; ExcReq = 1'b1;
        step();
        check("halt_exc.state", 32'(State), 32'd2);
        check("halt_exc.pc",    Pc, 32'h3040);
        check("halt_exc.vld",   32'(PcValid), 32'd0);

        // reset with inputs active, then replay boot while inputs are ignored
        Reset = 1'b1; Halt = 1'b1; RedirectValid = 1'b1; RedirectPC = 32'h5000;
        step();
        chk_boot("rst2");
        Reset = 1'b0;
        step();
        chk_boot("rst2_boot1");
        step();
        chk_run("rst2_run0", 32'h3000, 1'b0);
        idle_inputs();
        step();
        chk_run("rst2_run1", 32'h3004, 1'b0);
        step();
        chk_run("rst2_run2", 32'h3008, 1'b0);

        // 8-bit wrap
        s_reset = 1'b0;
        step();
        step();
        check("w8.state", 32'(s_state), 32'd1);
        check("w8.pc0",   32'(s_pc), 32'h00);
        s_redir_valid = 1'b1; s_redir_pc = 8'hFC;
        step();
        check("w8.pc_fc",   32'(s_pc), 32'hFC);
        check("w8.fexc_fc", 32'(s_fetch_exc), 32'd0);
        s_redir_valid = 1'b0;
        step();
        check("w8.wrap",      32'(s_pc), 32'h00);
        check("w8.wrap_fexc", 32'(s_fetch_exc), 32'd0);
        check("w8.wrap_vld",  32'(s_pc_valid), 32'd1);
        s_redir_valid = 1'b1; s_redir_pc = 8'h01;
        step();
        check("w8.mis_fexc", 32'(s_fetch_exc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
